// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  // Counter width able to hold the value n itself (0..n).
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO of fetched entries with flush; head is read combinationally.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fq_entry_t     i_data,
  output fq_entry_t     o_head,
  output logic [CW-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // Flush wins over both push and pop in the same cycle.
  assign do_push = i_push && !i_flush;
  assign do_pop  = i_pop && !i_flush && (count_q != '0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, discards stale returns
// after a redirect, and presents buffered instructions to IF/ID.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_vld,
  input  logic        i_rdy,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four
);

  localparam int CW = cnt_w(DEPTH);
  localparam int OW = cnt_w(MAX_OUTST);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] ret_pc_q, ret_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [CW-1:0] count;
  logic [31:0] used;
  logic [31:0] target_pc;
  logic        accept;
  logic        push;
  logic        pop;
  fq_entry_t   head;
  fq_entry_t   push_data;

  // Handshakes: a fetch transfers when o_imem_req && i_imem_gnt in the same
  // cycle; the head transfers when o_vld && i_rdy. Neither valid depends on
  // its own ready.
  assign target_pc  = i_redirect_pc & ~32'd3;
  assign used       = 32'(count) + 32'(outst_q);
  // Reserving FIFO space for in-flight requests means a push never finds it full.
  assign o_imem_req = i_reset && !i_redirect && (32'(outst_q) < MAX_OUTST) && (used < DEPTH);
  assign o_imem_addr = fetch_pc_q;
  assign accept     = o_imem_req && i_imem_gnt;
  assign push       = i_imem_rvalid && !i_redirect && (discard_q == '0);
  assign pop        = o_vld && i_rdy;
  assign push_data  = '{pc: ret_pc_q, instr: i_imem_rdata};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    ret_pc_d   = ret_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (i_redirect) begin
      fetch_pc_d = target_pc;
      ret_pc_d   = target_pc;
      outst_d    = outst_q - OW'(i_imem_rvalid);
      // Every request still unreturned after this cycle is stale.
      discard_d  = outst_d;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)   ret_pc_d   = ret_pc_q + 32'd4;
      if (i_imem_rvalid && (discard_q != '0)) discard_d = discard_q - OW'(1);
      case ({accept, i_imem_rvalid})
        2'b10:   outst_d = outst_q + OW'(1);
        2'b01:   outst_d = outst_q - OW'(1);
        default: outst_d = outst_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fetch_pc_q <= RESET_PC;
      ret_pc_q   <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ret_pc_q   <= ret_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (i_redirect),
    .i_data  (push_data),
    .o_head  (head),
    .o_count (count)
  );

  assign o_vld     = (count != '0);
  assign o_instr   = o_vld ? head.instr : NOP;
  assign o_pc      = o_vld ? head.pc : 32'd0;
  assign o_pc_four = o_vld ? (head.pc + 32'd4) : 32'd0;

endmodule
